// File: rtl/index_align_fifo_if.sv
// Handshake and status bundle between stage-0 CBFP index producer, the index
// alignment FIFO, and the downstream stage that consumes aligned indices.
interface index_align_fifo_if #(
  parameter int N     = 16,
  parameter int IDX_W = 5,
  parameter int DEPTH = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             wr_en;
  logic [IDX_W-1:0] idx_in  [0:N-1];
  logic             rd_en;
  logic [IDX_W-1:0] idx_out [0:N-1];
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             frame_done;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_en, idx_in, rd_en,
    input  idx_out, rd_valid, full, empty, count, frame_done, overflow, underflow
  );

  modport slave (
    input  wr_en, idx_in, rd_en,
    output idx_out, rd_valid, full, empty, count, frame_done, overflow, underflow
  );
endinterface

// File: rtl/index_align_fifo.sv
// Block FIFO that holds one frame of per-lane CBFP indices so they line up with
// the delayed data path; registered read with one cycle latency, no fall-through.
module index_align_fifo #(
  parameter int N     = 16,
  parameter int IDX_W = 5,
  parameter int DEPTH = 32  // must be a power of two so the pointers wrap for free
) (
  input  logic                clk,
  input  logic                rst,
  index_align_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef logic [N-1:0][IDX_W-1:0] word_t;

  word_t         mem [DEPTH];
  word_t         wr_word;
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW-1:0] fcnt;
  logic [CW-1:0] count_q;
  logic          full;
  logic          empty;
  logic          rd_acc;
  logic          wr_acc;

  always_comb begin
    for (int k = 0; k < N; k++) wr_word[k] = bus.idx_in[k];
  end

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  // A full FIFO still accepts a write when a read frees a slot in the same cycle.
  assign rd_acc = bus.rd_en && !empty;
  assign wr_acc = bus.wr_en && (!full || rd_acc);

  assign bus.full  = full;
  assign bus.empty = empty;
  assign bus.count = count_q;

  // NOTE: storage has no reset; stale entries are unreachable because count and
  // the pointers are cleared, and leaving it out keeps the array mappable to RAM.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wp] <= wr_word;
  end

  // NOTE: all state below uses non-blocking assignments so every register sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp             <= '0;
      rp             <= '0;
      fcnt           <= '0;
      count_q        <= '0;
      bus.rd_valid   <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.overflow   <= 1'b0;
      bus.underflow  <= 1'b0;
      for (int k = 0; k < N; k++) bus.idx_out[k] <= '0;
    end else begin
      if (wr_acc) begin
        wp   <= wp + 1'b1;
        fcnt <= fcnt + 1'b1;
      end

      if (rd_acc) begin
        rp <= rp + 1'b1;
        for (int k = 0; k < N; k++) bus.idx_out[k] <= mem[rp][k];
      end

      bus.rd_valid   <= rd_acc;
      bus.frame_done <= wr_acc && (fcnt == AW'(DEPTH - 1));

      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      if (bus.wr_en && full && !rd_acc) bus.overflow  <= 1'b1;
      if (bus.rd_en && empty)           bus.underflow <= 1'b1;
    end
  end
endmodule

// File: doc/index_align_fifo.md
INDEX_ALIGN_FIFO -- requirements
Module: index_align_fifo

Interface
REQ-001 The block SHALL have parameter N, default 16, giving the number of lanes per block.
REQ-002 The block SHALL have parameter IDX_W, default 5, giving the CBFP index width per lane.
REQ-003 The block SHALL have parameter DEPTH, default 32, giving the number of storable blocks (one 512-point frame); it SHALL be a power of two.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port wr_en, input, 1 bit: write request, driven by the stage-0 valid_out.
REQ-007 The block SHALL have port idx_in, input, N x IDX_W unpacked: the stage-0 cbfp_index lanes [0:N-1].
REQ-008 The block SHALL have port rd_en, input, 1 bit: read request from the downstream stage.
REQ-009 The block SHALL have port idx_out, output, N x IDX_W unpacked, registered: the read block.
REQ-010 The block SHALL have port rd_valid, output, 1 bit: idx_out is valid this cycle.
REQ-011 The block SHALL have ports full and empty, outputs, 1 bit each, combinational from count.
REQ-012 The block SHALL have port count, output, log2(DEPTH)+1 bits: the number of blocks stored.
REQ-013 The block SHALL have port frame_done, output, 1 bit: a one-cycle pulse when the DEPTH-th block of a frame is written.
REQ-014 The block SHALL have ports overflow and underflow, outputs, 1 bit each: sticky error flags.

Function
REQ-015 Storage SHALL be DEPTH entries of N*IDX_W bits, with write pointer wp and read pointer rp of log2(DEPTH) bits, each wrapping DEPTH-1 -> 0.
REQ-016 A write SHALL be accepted when wr_en=1 and (full=0 or a read is accepted in the same cycle); an accepted write stores idx_in at wp, and wp increments.
REQ-017 A read SHALL be accepted when rd_en=1 and empty=0; there is no fall-through, so data written this cycle is not readable this cycle.
REQ-018 On an accepted read, idx_out SHALL take mem[rp] on the next edge, rd_valid SHALL be 1 for that one cycle, and rp SHALL increment (read latency 1 cycle).
REQ-019 When no read is accepted, rd_valid SHALL be 0 and idx_out SHALL hold its last value.
REQ-020 count SHALL update as follows: +1 on write only, -1 on read only, unchanged on a simultaneous accepted write and read (including when full).
REQ-021 full SHALL equal (count==DEPTH) and empty SHALL equal (count==0).
REQ-022 wr_en=1 while full with no accepted read SHALL drop the data, leave pointers and count unchanged, and set overflow.
REQ-023 rd_en=1 while empty SHALL be ignored, including when wr_en=1 in the same cycle; rd_valid stays 0 and underflow is set.
REQ-024 A frame counter fcnt (log2(DEPTH) bits) SHALL increment on each accepted write and wrap at DEPTH-1 -> 0.
REQ-025 frame_done SHALL be 1 in the cycle after the accepted write at fcnt==DEPTH-1.
REQ-026 overflow and underflow SHALL stay set until rst.
REQ-027 The block SHALL perform no arithmetic on index values; lane k in SHALL equal lane k out, bit-exact.

Reset
REQ-028 While rst=1 at a clock edge, the following SHALL be cleared to 0: wp, rp, count, fcnt, rd_valid, frame_done, overflow, underflow and all idx_out lanes; empty SHALL then read 1 and full 0.
REQ-029 Stored memory contents need not be cleared.
REQ-030 rst asserted mid-frame SHALL discard all stored blocks, so the next write is fcnt=0.
REQ-031 wr_en and rd_en SHALL be ignored in any cycle where rst=1.

Verification
REQ-032 Write 3 blocks with lane k = k+i, where i is the block number, then read 3 back-to-back: rd_valid is high for 3 cycles, each 1 cycle after its rd_en, data is in order, count goes 3->0, and empty=1.
REQ-033 Write 32 consecutive blocks: frame_done pulses once, 1 cycle after the 32nd write, and full=1; a 33rd write with rd_en=0 sets overflow and count stays 32.
REQ-034 With full, assert wr_en and rd_en together: the oldest block is output, the new block is stored at the wrapped wp, count stays 32, and overflow stays 0.
REQ-035 When empty, assert wr_en and rd_en together: rd_valid=0, underflow=1, and count=1 afterwards.
REQ-036 Write 40 blocks interleaved with 40 reads so the pointers wrap: all 40 outputs match in order and frame_done pulses after the 32nd write only.
REQ-037 Apply rst for 1 cycle with count=10: count=0, idx_out=0 and the flags clear; the following write and read return the new data.
